// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + cin LSB first, one bit per clock, with a start/done handshake.
// Optional SERIAL_ADDER_OVF_EN adds a signed-overflow output captured alongside sum/cout.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic ha1_s, ha1_c, ha2_s, ha2_c, carry_next, last_bit;
  logic [WIDTH-1:0] sum_next;

  // Full-adder slice from two half-adder stages plus an OR for the carry.
  always_comb begin
    ha1_s      = a_sr[0] ^ b_sr[0];
    ha1_c      = a_sr[0] & b_sr[0];
    ha2_s      = ha1_s ^ carry;
    ha2_c      = ha1_s & carry;
    carry_next = ha1_c | ha2_c;
    sum_next   = {ha2_s, sum_sr[WIDTH-1:1]};
    last_bit   = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= carry_next;
          // Publish the result on the last bit so it is valid while done is high.
          if (last_bit) begin
            sum   <= sum_next;
            cout  <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ carry_next;
`endif
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
